// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbiter slice.
package uart_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;
  localparam int unsigned RETRY_CYCLES  = 4;
  localparam int unsigned RETRY_W       = $clog2(RETRY_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_ISSUE      = 2'd1,
    ST_WAIT_START = 2'd2,
    ST_WAIT_DONE  = 2'd3
  } arb_state_e;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Word-level link between the arbiter (master) and the UART transmitter (slave).
interface uart_tx_arbiter_if
  import uart_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) ();

  logic             tx_can_send;
  logic [WIDTH-1:0] tx_data;
  logic             tx_ready;

  modport master (
    output tx_can_send,
    output tx_data,
    input  tx_ready
  );

  modport slave (
    input  tx_can_send,
    input  tx_data,
    output tx_ready
  );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_pick #(
  parameter  int unsigned N     = 4,
  localparam int unsigned IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt_c,
  output logic [IDX_W-1:0] idx_c,
  output logic             found_c
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    gnt_c   = '0;
    idx_c   = '0;
    found_c = 1'b0;
    cand    = '0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = IDX_W'((32'(ptr) + k) % N);
      if (!found_c && req[cand]) begin
        found_c     = 1'b1;
        gnt_c[cand] = 1'b1;
        idx_c       = cand;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding one UART transmitter, with packet lock and start retry.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter  int unsigned NUM_REQ = 4,
  parameter  int unsigned WIDTH   = DEFAULT_WIDTH,
  localparam int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic                          clock,
  input  logic                          resetn,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0][WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  uart_tx_arbiter_if.master             tx,
  output logic [IDX_W-1:0]              grant_id,
  output logic                          busy,
  output logic                          done
);

  arb_state_e         state_q, state_d;
  logic [IDX_W-1:0]   last_grant_q, last_grant_d;
  logic [IDX_W-1:0]   grant_d;
  logic [IDX_W-1:0]   ptr;
  logic [IDX_W-1:0]   pick_idx;
  logic [NUM_REQ-1:0] pick_gnt;
  logic               pick_found;
  logic [NUM_REQ-1:0] grant_mask;
  logic [NUM_REQ-1:0] eligible;
  logic               last_q, last_d;
  logic               lock_q, lock_d;
  logic               bypass;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic               can_send_d;
  logic               busy_d;
  logic               done_d;
  logic [WIDTH-1:0]   data_d;

  // Search starts one past the last completed grant; a held lock admits only the owner.
  assign ptr        = (last_grant_q == IDX_W'(NUM_REQ - 1)) ? '0 : last_grant_q + IDX_W'(1);
  assign grant_mask = NUM_REQ'(1) << grant_id;
  assign eligible   = lock_q ? (req_valid & grant_mask) : req_valid;
  assign bypass     = !last_q && req_valid[grant_id];

  rr_pick #(
    .N (NUM_REQ)
  ) u_rr_pick (
    .req     (eligible),
    .ptr     (ptr),
    .gnt_c   (pick_gnt),
    .idx_c   (pick_idx),
    .found_c (pick_found)
  );

  // State register.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (tx.tx_ready && pick_found) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        state_d = ST_WAIT_START;
      end
      ST_WAIT_START: begin
        if (!tx.tx_ready)                                 state_d = ST_WAIT_DONE;
        else if (retry_q == RETRY_W'(RETRY_CYCLES - 1)) state_d = ST_ISSUE;
      end
      ST_WAIT_DONE: begin
        if (tx.tx_ready) state_d = bypass ? ST_ISSUE : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output and datapath logic; req_ready is combinational so a word is taken
  // in the same cycle its data is latched.
  always_comb begin
    req_ready    = '0;
    data_d       = tx.tx_data;
    grant_d      = grant_id;
    last_d       = last_q;
    lock_d       = lock_q;
    last_grant_d = last_grant_q;
    retry_d      = '0;
    done_d       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (tx.tx_ready && pick_found) begin
          req_ready = pick_gnt;
          data_d    = req_data[pick_idx];
          last_d    = req_last[pick_idx];
          grant_d   = pick_idx;
        end
      end
      ST_WAIT_START: begin
        if (tx.tx_ready && retry_q != RETRY_W'(RETRY_CYCLES - 1)) retry_d = retry_q + RETRY_W'(1);
      end
      ST_WAIT_DONE: begin
        if (tx.tx_ready) begin
          done_d       = 1'b1;
          last_grant_d = grant_id;
          if (last_q) begin
            lock_d = 1'b0;
          end else if (req_valid[grant_id]) begin
            req_ready = grant_mask;
            data_d    = req_data[grant_id];
            last_d    = req_last[grant_id];
          end else begin
            lock_d = 1'b1;
          end
        end
      end
      default: ;
    endcase
    if (!resetn) req_ready = '0;
    can_send_d = (state_d == ST_ISSUE);
    busy_d     = (state_d != ST_IDLE);
  end

  // Registered outputs and datapath state.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      tx.tx_can_send <= 1'b0;
      tx.tx_data     <= '0;
      grant_id       <= IDX_W'(NUM_REQ - 1);
      busy           <= 1'b0;
      done           <= 1'b0;
      last_q         <= 1'b0;
      lock_q         <= 1'b0;
      last_grant_q   <= IDX_W'(NUM_REQ - 1);
      retry_q        <= '0;
    end else begin
      tx.tx_can_send <= can_send_d;
      tx.tx_data     <= data_d;
      grant_id       <= grant_d;
      busy           <= busy_d;
      done           <= done_d;
      last_q         <= last_d;
      lock_q         <= lock_d;
      last_grant_q   <= last_grant_d;
      retry_q        <= retry_d;
    end
  end

  a_ready_onehot: assert property (@(posedge clock) disable iff (!resetn) $onehot0(req_ready));
  a_send_in_issue: assert property (@(posedge clock) disable iff (!resetn)
                                    tx.tx_can_send |-> (state_q == ST_ISSUE));

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters (2..8).
REQ-002 Parameter WIDTH, default 8, data word width; equals the transmitter's word width.
REQ-003 Port clock  input  1  system clock, all state updates on rising edge.
REQ-004 Port resetn  input  1  reset, asynchronous, active-low.
REQ-005 Port req_valid  input  NUM_REQ  per-requester word available.
REQ-006 Port req_data  input  NUM_REQ x WIDTH  per-requester word.
REQ-007 Port req_last  input  NUM_REQ  word is last of its packet; 0 keeps the grant for the next word.
REQ-008 Port req_ready  output  NUM_REQ  one-hot accept pulse; word taken when valid&ready.
REQ-009 Port tx_can_send  output  1  drives transmitter can_send_next_word.
REQ-010 Port tx_data  output  WIDTH  drives transmitter data; stable while tx_can_send=1.
REQ-011 Port tx_ready  input  1  transmitter ready; 1 = idle, 0 = frame in progress.
REQ-012 Port grant_id  output  clog2(NUM_REQ)  index of the current or last granted requester.
REQ-013 Port busy  output  1  1 in any state other than IDLE.
REQ-014 Port done  output  1  one-cycle pulse when a granted word's frame completes; grant_id is valid with it.

Function
REQ-015 The FSM SHALL have states IDLE, ISSUE, WAIT_START and WAIT_DONE.
REQ-016 In IDLE with tx_ready=1 and any req_valid=1, the block SHALL pick a requester round-robin, starting at (last_grant+1) mod NUM_REQ.
REQ-017 It SHALL then pulse that requester's req_ready for one cycle, latch req_data into tx_data, latch req_last, set grant_id and go to ISSUE.
REQ-018 In IDLE with no valid requester or tx_ready=0, no req_ready SHALL assert and the state SHALL hold.
REQ-019 In ISSUE, tx_can_send SHALL be 1 for exactly one cycle, then the FSM SHALL go to WAIT_START.
REQ-020 In WAIT_START, the FSM SHALL wait for tx_ready=0 and then go to WAIT_DONE.
REQ-021 If tx_ready stays 1 for 4 cycles in WAIT_START, the FSM SHALL return to ISSUE and re-issue the same word (retry).
REQ-022 In WAIT_DONE, on tx_ready=1 the block SHALL pulse done and update last_grant to grant_id.
REQ-023 In the same WAIT_DONE exit, if latched last=1 the FSM SHALL go to IDLE.
REQ-024 If latched last=0 and req_valid[grant_id]=1, the block SHALL accept that requester's next word and go to ISSUE, bypassing arbitration.
REQ-025 If latched last=0 and req_valid[grant_id]=0, the block SHALL enter IDLE holding a lock, so only grant_id may win until a word with last=1 is sent.
REQ-026 At most one req_ready bit SHALL be 1 in any cycle, and never in ISSUE, WAIT_START or WAIT_DONE except per REQ-024.
REQ-027 The round-robin pointer SHALL wrap from NUM_REQ-1 to 0, and each requester SHALL be granted within NUM_REQ packets.
REQ-028 A req_valid drop without acceptance SHALL be legal, with no side effects.
REQ-029 A default/illegal FSM state SHALL return to IDLE with tx_can_send=0.

Reset
REQ-030 On resetn=0: state=IDLE, tx_can_send=0, tx_data=0, req_ready=0, done=0, busy=0, grant_id=NUM_REQ-1 (so requester 0 wins first), lock cleared, retry counter=0.
REQ-031 Reset asserted mid-frame SHALL abort the sequence immediately; no done pulse SHALL follow after release.

Structure
REQ-032 A shared package uart_pkg SHALL hold the FSM state enum, DEFAULT_WIDTH and RETRY_CYCLES=4.
REQ-033 Round-robin selection SHALL be a sub-module rr_pick (request vector + pointer -> one-hot grant + index), purely combinational.
REQ-034 The block SHALL connect to the transmitter via the transmitter's existing interface modport; the discrete port list above defines the signal semantics.

Verification
REQ-035 Single: req_valid=0001, data 0x55, last=1 -> req_ready[0] one pulse, tx_can_send one pulse with tx_data=0x55, done after tx_ready rises, grant_id=0.
REQ-036 Fairness: all four valid continuously, last=1 -> grants in order 0,1,2,3,0; no requester gets two grants in a row.
REQ-037 Packet: requester 2 sends 0xA1(last=0) then 0xA2(last=1) while 1 and 3 are valid -> 0xA1 and 0xA2 back-to-back from requester 2, then requester 3 is granted.
REQ-038 Lock: requester 1 sends last=0, then drops valid for 20 cycles while 0 is valid -> no grant to 0 until requester 1 completes a last=1 word.
REQ-039 Retry: tx_ready held at 1 through ISSUE for 4 cycles -> second tx_can_send pulse with the same tx_data, and no extra req_ready.
REQ-040 Reset during WAIT_DONE -> all outputs at reset values next cycle, no done pulse; the next request is granted to requester 0.
